rtc_char_stream: RTL and testbench

Downstream consumer of the RTC register extractor: snapshots the nine BCD time/date/timer bytes on a `load` strobe and streams them as 26 ASCII characters with a valid/ready handshake to the display text-buffer writer. Fixed frame "DD/MM/YY HH:MM:SS HH:MM:SS" (date, time, timer). Decouples the slow RTC read cycle from the character-RAM write port.

---
 rtl/rtc_pkg.sv | 96 +++++++++
 rtl/bcd_nibble_ascii.sv | 24 ++
 rtl/rtc_char_stream.sv | 124 ++++++++++++
 tb/tb_rtc_char_stream.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rtc_pkg.sv
// Shared definitions for the RTC character streamer: FSM states, frame
// geometry, ASCII constants and the frame-position multiplexer.
package rtc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int         FRAME_LEN = 26;
  localparam logic [4:0] LAST_IDX  = 5'(FRAME_LEN - 1);

  localparam logic [7:0] ASCII_ZERO  = 8'h30;
  localparam logic [7:0] ASCII_SLASH = 8'h2F;
  localparam logic [7:0] ASCII_COLON = 8'h3A;
  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] ASCII_QMARK = 8'h3F;

  // First (tens) digit position of each field, plus separator positions.
  localparam logic [4:0] POS_DIA   = 5'd0;
  localparam logic [4:0] POS_MES   = 5'd3;
  localparam logic [4:0] POS_YEAR  = 5'd6;
  localparam logic [4:0] POS_HORA  = 5'd9;
  localparam logic [4:0] POS_MIN   = 5'd12;
  localparam logic [4:0] POS_SEG   = 5'd15;
  localparam logic [4:0] POS_HCR   = 5'd18;
  localparam logic [4:0] POS_MCR   = 5'd21;
  localparam logic [4:0] POS_SCR   = 5'd24;
  localparam logic [4:0] POS_SL1   = 5'd2;
  localparam logic [4:0] POS_SL2   = 5'd5;
  localparam logic [4:0] POS_SP1   = 5'd8;
  localparam logic [4:0] POS_CO1   = 5'd11;
  localparam logic [4:0] POS_CO2   = 5'd14;
  localparam logic [4:0] POS_SP2   = 5'd17;
  localparam logic [4:0] POS_CO3   = 5'd20;
  localparam logic [4:0] POS_CO4   = 5'd23;

  // Field order matches the frame order, date first.
  typedef struct packed {
    logic [7:0] dia;
    logic [7:0] mes;
    logic [7:0] year;
    logic [7:0] hora;
    logic [7:0] min;
    logic [7:0] seg;
    logic [7:0] hcr;
    logic [7:0] mcr;
    logic [7:0] scr;
  } snap_t;

  typedef struct packed {
    logic       is_digit;
    logic [3:0] nibble;
    logic [7:0] sep;
  } pos_sel_t;

  // Pick either a BCD nibble or a separator for a frame position.
  function automatic pos_sel_t select_pos(input snap_t s, input logic [4:0] idx);
    pos_sel_t r;
    r.is_digit = 1'b1;
    r.nibble   = 4'h0;
    r.sep      = ASCII_SPACE;
    case (idx)
      POS_DIA:         r.nibble = s.dia[7:4];
      POS_DIA  + 5'd1: r.nibble = s.dia[3:0];
      POS_MES:         r.nibble = s.mes[7:4];
      POS_MES  + 5'd1: r.nibble = s.mes[3:0];
      POS_YEAR:        r.nibble = s.year[7:4];
      POS_YEAR + 5'd1: r.nibble = s.year[3:0];
      POS_HORA:        r.nibble = s.hora[7:4];
      POS_HORA + 5'd1: r.nibble = s.hora[3:0];
      POS_MIN:         r.nibble = s.min[7:4];
      POS_MIN  + 5'd1: r.nibble = s.min[3:0];
      POS_SEG:         r.nibble = s.seg[7:4];
      POS_SEG  + 5'd1: r.nibble = s.seg[3:0];
      POS_HCR:         r.nibble = s.hcr[7:4];
      POS_HCR  + 5'd1: r.nibble = s.hcr[3:0];
      POS_MCR:         r.nibble = s.mcr[7:4];
      POS_MCR  + 5'd1: r.nibble = s.mcr[3:0];
      POS_SCR:         r.nibble = s.scr[7:4];
      POS_SCR  + 5'd1: r.nibble = s.scr[3:0];
      POS_SL1, POS_SL2: begin
        r.is_digit = 1'b0;
        r.sep      = ASCII_SLASH;
      end
      POS_CO1, POS_CO2, POS_CO3, POS_CO4: begin
        r.is_digit = 1'b0;
        r.sep      = ASCII_COLON;
      end
      default: r.is_digit = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/bcd_nibble_ascii.sv
// Combinational BCD nibble to ASCII digit converter.
// With RTC_BCD_CHECK_EN defined, nibbles above 9 become '?' and raise err;
// otherwise the raw 0x30+nibble code is produced and err stays 0.
module bcd_nibble_ascii
  import rtc_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [7:0] ascii,
  output logic       err
);

  // Digit encoding with optional range check.
  always_comb begin
    ascii = ASCII_ZERO + {4'h0, nibble};
    err   = 1'b0;
`ifdef RTC_BCD_CHECK_EN
    if (nibble > 4'd9) begin
      ascii = ASCII_QMARK;
      err   = 1'b1;
    end
`endif
  end

endmodule

// File: rtl/rtc_char_stream.sv
// Snapshots nine BCD RTC bytes on load and streams the fixed 26-character
// frame "DD/MM/YY HH:MM:SS HH:MM:SS" over a valid/ready handshake.
// Optional nibble range checking is selected with RTC_BCD_CHECK_EN
// (implemented in bcd_nibble_ascii); without it bcd_err never rises.
module rtc_char_stream
  import rtc_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       load,
  input  logic [7:0] year,
  input  logic [7:0] mes,
  input  logic [7:0] dia,
  input  logic [7:0] hora,
  input  logic [7:0] min,
  input  logic [7:0] seg,
  input  logic [7:0] horacrono,
  input  logic [7:0] mincrono,
  input  logic [7:0] segcrono,
  input  logic       char_ready,
  output logic       char_valid,
  output logic [7:0] char_out,
  output logic [4:0] char_addr,
  output logic       busy,
  output logic       done,
  output logic       bcd_err
);

  state_t     state, state_n;
  snap_t      snap, snap_n, live;
  logic [4:0] idx, idx_n;
  logic       valid_n, done_n, err_n;
  logic [7:0] char_n;
  pos_sel_t   sel;
  logic [7:0] digit_ascii;
  logic       digit_err;

  assign live = {dia, mes, year, hora, min, seg, horacrono, mincrono, segcrono};
  assign char_addr = idx;

  // Next-state, snapshot capture and position counter.
  always_comb begin
    state_n = state;
    idx_n   = idx;
    snap_n  = snap;
    valid_n = 1'b0;
    done_n  = 1'b0;
    case (state)
      IDLE: begin
        if (load) begin
          snap_n  = live;
          idx_n   = 5'd0;
          state_n = SEND;
          valid_n = 1'b1;
        end
      end
      SEND: begin
        valid_n = 1'b1;
        if (char_ready) begin
          if (idx == LAST_IDX) begin
            state_n = DONE;
            valid_n = 1'b0;
            done_n  = 1'b1;
          end else begin
            idx_n = idx + 5'd1;
          end
        end
      end
      DONE: begin
        state_n = IDLE;
        idx_n   = 5'd0;
      end
      default: state_n = IDLE;
    endcase
  end

  // Character for the position being presented next cycle; computed from
  // the next snapshot/index so char_out can be a plain register.
  assign sel = select_pos(snap_n, idx_n);

  bcd_nibble_ascii u_conv (
    .nibble (sel.nibble),
    .ascii  (digit_ascii),
    .err    (digit_err)
  );

  // Output character and sticky error; error restarts on each accepted load.
  always_comb begin
    char_n = char_out;
    err_n  = bcd_err;
    if (valid_n) begin
      char_n = sel.is_digit ? digit_ascii : sel.sep;
    end
    if (state == IDLE && load) begin
      err_n = sel.is_digit & digit_err;
    end else if (valid_n) begin
      err_n = bcd_err | (sel.is_digit & digit_err);
    end
  end

  // State, snapshot and registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      idx        <= 5'd0;
      snap       <= '0;
      char_valid <= 1'b0;
      char_out   <= 8'h00;
      busy       <= 1'b0;
      done       <= 1'b0;
      bcd_err    <= 1'b0;
    end else begin
      state      <= state_n;
      idx        <= idx_n;
      snap       <= snap_n;
      char_valid <= valid_n;
      char_out   <= char_n;
      busy       <= (state_n != IDLE);
      done       <= done_n;
      bcd_err    <= err_n;
    end
  end

endmodule

// File: tb/tb_rtc_char_stream.sv
// Testbench for rtc_char_stream: table-driven frames, hand-written stall /
// load-ignore / reset / BCD-error sequences, and randomized frames checked
// against a frame-level reference model.
module tb_rtc_char_stream;

  logic       clock = 1'b0;
  logic       reset, load, char_ready;
  logic [7:0] year, mes, dia, hora, min, seg, horacrono, mincrono, segcrono;
  logic       char_valid, busy, done, bcd_err;
  logic [7:0] char_out;
  logic [4:0] char_addr;

  int checks = 0;
  int errors = 0;

  rtc_char_stream dut (
    .clock      (clock),
    .reset      (reset),
    .load       (load),
    .year       (year),
    .mes        (mes),
    .dia        (dia),
    .hora       (hora),
    .min        (min),
    .seg        (seg),
    .horacrono  (horacrono),
    .mincrono   (mincrono),
    .segcrono   (segcrono),
    .char_ready (char_ready),
    .char_valid (char_valid),
    .char_out   (char_out),
    .char_addr  (char_addr),
    .busy       (busy),
    .done       (done),
    .bcd_err    (bcd_err)
  );

  always #5 clock = ~clock;

  // Reference model: frame contents and transaction-level position.
  int         m_phase;      // 0 idle, 1 streaming, 2 done pulse
  int         m_pos;
  logic [7:0] m_frame [26];
  logic       m_bad   [26];
  logic       m_err;
  logic       m_fresh;      // no frame since reset: char_out/addr still zero

  typedef struct {
    logic [7:0] b [9];      // dia, mes, year, hora, min, seg, hcr, mcr, scr
    string      plain;
    string      chk;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] dig(input logic [3:0] n);
`ifdef RTC_BCD_CHECK_EN
    if (n > 4'd9) return 8'h3F;
`endif
    return 8'h30 + {4'h0, n};
  endfunction

  function automatic logic digbad(input logic [3:0] n);
`ifdef RTC_BCD_CHECK_EN
    return n > 4'd9;
`else
    return (n > 4'd9) && 1'b0;
`endif
  endfunction

  // Lay out the frame from the live inputs: nine digit pairs with separators.
  task automatic build_frame();
    logic [7:0] b   [9];
    logic [7:0] sep [8];
    b   = '{dia, mes, year, hora, min, seg, horacrono, mincrono, segcrono};
    sep = '{8'h2F, 8'h2F, 8'h20, 8'h3A, 8'h3A, 8'h20, 8'h3A, 8'h3A};
    for (int f = 0; f < 9; f++) begin
      m_frame[3*f]     = dig(b[f][7:4]);
      m_bad[3*f]       = digbad(b[f][7:4]);
      m_frame[3*f + 1] = dig(b[f][3:0]);
      m_bad[3*f + 1]   = digbad(b[f][3:0]);
      if (f < 8) begin
        m_frame[3*f + 2] = sep[f];
        m_bad[3*f + 2]   = 1'b0;
      end
    end
  endtask

  task automatic model_update();
    if (reset) begin
      m_phase = 0;
      m_pos   = 0;
      m_err   = 1'b0;
      m_fresh = 1'b1;
    end else begin
      case (m_phase)
        0: if (load) begin
          build_frame();
          m_phase = 1;
          m_pos   = 0;
          m_err   = m_bad[0];
          m_fresh = 1'b0;
        end
        1: if (char_ready) begin
          if (m_pos == 25) m_phase = 2;
          else begin
            m_pos = m_pos + 1;
            m_err = m_err | m_bad[m_pos];
          end
        end
        default: m_phase = 0;
      endcase
    end
  endtask

  // One clock: advance the model at the edge, compare just after it.
  task automatic tick();
    logic       pre_stall;
    logic [7:0] pre_out;
    logic [4:0] pre_addr;
    pre_stall = (m_phase == 1) && !char_ready && !reset;
    pre_out   = char_out;
    pre_addr  = char_addr;
    @(posedge clock);
    model_update();
    #1;
    check("char_valid", 32'(char_valid), 32'(m_phase == 1));
    check("busy", 32'(busy), 32'(m_phase != 0));
    check("done", 32'(done), 32'(m_phase == 2));
    check("bcd_err", 32'(bcd_err), 32'(m_err));
    if (m_phase == 1) begin
      check("char_addr", 32'(char_addr), 32'(m_pos));
      check($sformatf("char_out@%0d", m_pos), 32'(char_out), 32'(m_frame[m_pos]));
    end
    if (m_fresh && m_phase == 0) begin
      check("idle_char_out", 32'(char_out), 32'h0);
      check("idle_char_addr", 32'(char_addr), 32'h0);
    end
    if (pre_stall) begin
      check("stall_out_stable", 32'(char_out), 32'(pre_out));
      check("stall_addr_stable", 32'(char_addr), 32'(pre_addr));
    end
  endtask

  task automatic set_inputs(input logic [7:0] b [9]);
    dia = b[0]; mes = b[1]; year = b[2]; hora = b[3]; min = b[4];
    seg = b[5]; horacrono = b[6]; mincrono = b[7]; segcrono = b[8];
  endtask

  task automatic scramble_inputs();
    dia = 8'($urandom); mes = 8'($urandom); year = 8'($urandom);
    hora = 8'($urandom); min = 8'($urandom); seg = 8'($urandom);
    horacrono = 8'($urandom); mincrono = 8'($urandom); segcrono = 8'($urandom);
  endtask

  // Stream one frame. mode 0: ready always, 1: ready low on the first and
  // every other cycle, 2: random ready with live inputs churning.
  // load_at: address at which a (to be ignored) load with new inputs is
  // pulsed; reset_at: address at which reset is applied (-1 = never).
  task automatic run_frame(input int mode, input int load_at, input int reset_at,
                           output int done_t, output logic [7:0] got [26]);
    int t;
    bit injected;
    t        = 0;
    injected = 0;
    done_t   = -1;
    for (int i = 0; i < 26; i++) got[i] = 8'hxx;
    load       = 1'b1;
    char_ready = (mode != 1);
    tick();
    load = 1'b0;
    while (t < 300) begin
      case (mode)
        0:       char_ready = 1'b1;
        1:       char_ready = (t % 2 == 1);
        default: char_ready = 1'($urandom_range(0, 1));
      endcase
      if (mode == 2) scramble_inputs();
      load = 1'b0;
      if (!injected && char_valid && int'(char_addr) == load_at) begin
        load = 1'b1;
        injected = 1;
        if (mode != 2) begin
          dia = 8'h44; mes = 8'h44; year = 8'h44; hora = 8'h44; min = 8'h44;
          seg = 8'h44; horacrono = 8'h44; mincrono = 8'h44; segcrono = 8'h44;
        end
      end
      if (reset_at >= 0 && char_valid && int'(char_addr) == reset_at) begin
        load  = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("reset_valid", 32'(char_valid), 32'h0);
        check("reset_busy", 32'(busy), 32'h0);
        check("reset_no_done", 32'(done), 32'h0);
        check("reset_char_out", 32'(char_out), 32'h0);
        done_t = -2;
        return;
      end
      if (char_valid && char_ready) got[char_addr] = char_out;
      tick();
      t++;
      if (done) begin
        done_t = t;
        break;
      end
    end
    if (done_t == -1) check("frame_timeout", 32'h0, 32'h1);
    // A load presented in the done cycle must be ignored.
    load = (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
    tick();
    load = 1'b0;
    check("idle_after_done", 32'(busy), 32'h0);
  endtask

  task automatic check_frame(input string tag, input logic [7:0] got [26], input string exp);
    logic [7:0] e;
    for (int i = 0; i < 26; i++) begin
      e = exp[i];
      check($sformatf("%s[%0d]", tag, i), 32'(got[i]), 32'(e));
    end
  endtask

  function automatic string exp_of(input int v);
`ifdef RTC_BCD_CHECK_EN
    return vecs[v].chk;
`else
    return vecs[v].plain;
`endif
  endfunction

  initial begin
    logic [7:0] got [26];
    int dt;

    vecs[0].b = '{8'h23, 8'h03, 8'h16, 8'h11, 8'h08, 8'h28, 8'h00, 8'h05, 8'h59};
    vecs[0].plain = "23/03/16 11:08:28 00:05:59";
    vecs[0].chk   = "23/03/16 11:08:28 00:05:59";
    vecs[1].b = '{8'h99, 8'h99, 8'h99, 8'h99, 8'h99, 8'h99, 8'h99, 8'h99, 8'h99};
    vecs[1].plain = "99/99/99 99:99:99 99:99:99";
    vecs[1].chk   = "99/99/99 99:99:99 99:99:99";
    vecs[2].b = '{8'h23, 8'h03, 8'h16, 8'h11, 8'h08, 8'h7A, 8'h00, 8'h05, 8'h59};
    vecs[2].plain = "23/03/16 11:08:7: 00:05:59";
    vecs[2].chk   = "23/03/16 11:08:7? 00:05:59";
    vecs[3].b = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    vecs[3].plain = "00/00/00 00:00:00 00:00:00";
    vecs[3].chk   = "00/00/00 00:00:00 00:00:00";
    vecs[4].b = '{8'h31, 8'h12, 8'h99, 8'h23, 8'h59, 8'h59, 8'h99, 8'h59, 8'h59};
    vecs[4].plain = "31/12/99 23:59:59 99:59:59";
    vecs[4].chk   = "31/12/99 23:59:59 99:59:59";
    vecs[5].b = '{8'hB5, 8'h01, 8'h20, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    vecs[5].plain = ";5/01/20 00:00:00 00:00:00";
    vecs[5].chk   = "?5/01/20 00:00:00 00:00:00";

    m_phase = 0; m_pos = 0; m_err = 1'b0; m_fresh = 1'b1;
    reset = 1'b1; load = 1'b0; char_ready = 1'b0;
    set_inputs(vecs[3].b);
    tick();
    tick();
    check("rst_char_valid", 32'(char_valid), 32'h0);
    check("rst_char_out", 32'(char_out), 32'h0);
    check("rst_char_addr", 32'(char_addr), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_done", 32'(done), 32'h0);
    check("rst_bcd_err", 32'(bcd_err), 32'h0);
    reset = 1'b0;
    tick();

    // Table-driven frames with ready held high: done 26 edges after load.
    for (int v = 0; v < 6; v++) begin
      set_inputs(vecs[v].b);
      run_frame(0, -1, -1, dt, got);
      check($sformatf("done_latency_v%0d", v), 32'(dt), 32'd26);
      check_frame($sformatf("frame_v%0d", v), got, exp_of(v));
    end

    // Alternating stalls: each character takes two cycles.
    set_inputs(vecs[0].b);
    run_frame(1, -1, -1, dt, got);
    check("done_latency_stall", 32'(dt), 32'd52);
    check_frame("frame_stall", got, exp_of(0));

    // Load with new inputs at addr 10 is ignored.
    set_inputs(vecs[0].b);
    run_frame(0, 10, -1, dt, got);
    check("done_latency_midload", 32'(dt), 32'd26);
    check_frame("frame_midload", got, exp_of(0));

    // Reset at addr 15 abandons the frame; next load restarts from addr 0.
    set_inputs(vecs[0].b);
    run_frame(0, -1, 15, dt, got);
    check("reset_abandon", 32'(dt), 32'hFFFF_FFFE);
    set_inputs(vecs[0].b);
    run_frame(0, -1, -1, dt, got);
    check("done_latency_after_reset", 32'(dt), 32'd26);
    check_frame("frame_after_reset", got, exp_of(0));

    // Invalid seg nibble: error flag persists until the next load.
    set_inputs(vecs[2].b);
    run_frame(0, -1, -1, dt, got);
`ifdef RTC_BCD_CHECK_EN
    check("bcd_err_held", 32'(bcd_err), 32'h1);
`else
    check("bcd_err_held", 32'(bcd_err), 32'h0);
`endif
    check("seg_tens", 32'(got[15]), 32'h37);
    set_inputs(vecs[0].b);
    load = 1'b1;
    tick();
    load = 1'b0;
    check("bcd_err_cleared", 32'(bcd_err), 32'h0);
    char_ready = 1'b1;
    for (int i = 0; i < 28; i++) tick();

    // Randomized frames against the model.
    for (int r = 0; r < 20; r++) begin
      scramble_inputs();
      run_frame(2, int'($urandom_range(0, 25)),
                ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 25)) : -1,
                dt, got);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
